// File: rtl/ucie_sb_pkg.sv
// Sideband message codes, comparator control codes and point-test FSM
// encoding shared by the D2C point-test initiator and responder.
package ucie_sb_pkg;

  localparam int SB_CODE_W = 4;

  localparam logic [SB_CODE_W-1:0] START_REQ       = 4'd1;
  localparam logic [SB_CODE_W-1:0] START_RESP      = 4'd2;
  localparam logic [SB_CODE_W-1:0] LFSR_CLR_REQ    = 4'd3;
  localparam logic [SB_CODE_W-1:0] LFSR_CLR_RESP   = 4'd4;
  localparam logic [SB_CODE_W-1:0] COUNT_DONE_REQ  = 4'd5;
  localparam logic [SB_CODE_W-1:0] COUNT_DONE_RESP = 4'd6;
  localparam logic [SB_CODE_W-1:0] END_REQ         = 4'd7;
  localparam logic [SB_CODE_W-1:0] END_RESP        = 4'd8;

  typedef enum logic [1:0] {
    CW_IDLE    = 2'b00,
    CW_CLEAR   = 2'b01,
    CW_COMPARE = 2'b10,
    CW_RSVD    = 2'b11
  } cw_e;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_SEND_START_RESP,
    ST_WAIT_CLR,
    ST_SEND_CLR_RESP,
    ST_COMPARE,
    ST_SEND_CNT_RESP,
    ST_WAIT_END,
    ST_SEND_END_RESP,
    ST_FINISHED
  } pt_state_e;

  // States that wait on the partner and are therefore subject to timeout.
  function automatic logic is_wait_state(pt_state_e s);
    return (s == ST_WAIT_START) || (s == ST_WAIT_CLR) ||
           (s == ST_COMPARE)    || (s == ST_WAIT_END);
  endfunction

endpackage

// File: rtl/pt_timeout_counter.sv
// Cycle counter for point-test request waits: synchronous clear, count
// enable, combinational terminal flag on the last counted cycle.
module pt_timeout_counter #(
  parameter int CYCLES = 800000,
  parameter int W      = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  // Firing on CYCLES-1 lets the FSM leave on exactly the CYCLES-th wait cycle.
  assign tc = en && (cnt == W'(CYCLES - 1));

endmodule

// File: rtl/rx_d2c_point_test_responder.sv
// Partner-side responder for the RX-initiated D2C point test: answers SB
// requests, steers the mainband comparator and latches the lane result.
module rx_d2c_point_test_responder
  import ucie_sb_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int NUM_LANES      = 16,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx_d2c_pt_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_sb_burst_count,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_tx_valid,
  input  logic [NUM_LANES-1:0]    i_lane_error,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic [1:0]              o_comparator_cw,
  output logic                    o_burst_count,
  output logic [NUM_LANES-1:0]    o_lane_result,
  output logic                    o_result_pass,
  output logic                    o_timeout,
  output logic                    o_rx_d2c_pt_done_rx
);

  pt_state_e state;
  logic      tmo_tc;
  logic      in_wait;
  logic      send_ok;

  // Wait states are always bracketed by non-wait states, so clearing outside
  // them is equivalent to clearing on every state change.
  assign in_wait = is_wait_state(state);
  // A busy edge while our initiator is also talking belongs to its message.
  assign send_ok = i_falling_edge_busy && !i_tx_valid;

  pt_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES),
    .W      (TIMEOUT_W)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .tc      (tmo_tc)
  );

  function automatic logic req_is(logic [SB_MSG_WIDTH-1:0] code, logic [SB_CODE_W-1:0] want);
    return code == SB_MSG_WIDTH'(want);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= ST_IDLE;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_comparator_cw     <= CW_IDLE;
      o_burst_count       <= 1'b0;
      o_lane_result       <= '0;
      o_result_pass       <= 1'b0;
      o_timeout           <= 1'b0;
      o_rx_d2c_pt_done_rx <= 1'b0;
    end else if (!i_rx_d2c_pt_en) begin
      // Burst count is deliberately kept across IDLE.
      state               <= ST_IDLE;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_comparator_cw     <= CW_IDLE;
      o_lane_result       <= '0;
      o_result_pass       <= 1'b0;
      o_timeout           <= 1'b0;
      o_rx_d2c_pt_done_rx <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_WAIT_START;

        ST_WAIT_START:
          if (i_rx_msg_valid && req_is(i_decoded_SB_msg, START_REQ)) begin
            o_burst_count       <= i_sb_burst_count;
            o_encoded_SB_msg_rx <= SB_MSG_WIDTH'(START_RESP);
            o_valid_rx          <= 1'b1;
            state               <= ST_SEND_START_RESP;
          end else if (tmo_tc) begin
            o_timeout <= 1'b1; o_comparator_cw <= CW_IDLE; o_valid_rx <= 1'b0;
            o_rx_d2c_pt_done_rx <= 1'b1; state <= ST_FINISHED;
          end

        ST_SEND_START_RESP:
          if (send_ok) begin
            o_valid_rx <= 1'b0;
            state      <= ST_WAIT_CLR;
          end

        ST_WAIT_CLR:
          if (i_rx_msg_valid && req_is(i_decoded_SB_msg, LFSR_CLR_REQ)) begin
            o_comparator_cw     <= CW_CLEAR;
            o_encoded_SB_msg_rx <= SB_MSG_WIDTH'(LFSR_CLR_RESP);
            o_valid_rx          <= 1'b1;
            state               <= ST_SEND_CLR_RESP;
          end else if (tmo_tc) begin
            o_timeout <= 1'b1; o_comparator_cw <= CW_IDLE; o_valid_rx <= 1'b0;
            o_rx_d2c_pt_done_rx <= 1'b1; state <= ST_FINISHED;
          end

        ST_SEND_CLR_RESP:
          if (send_ok) begin
            o_valid_rx      <= 1'b0;
            o_comparator_cw <= CW_COMPARE;
            state           <= ST_COMPARE;
          end

        ST_COMPARE:
          if (i_rx_msg_valid && req_is(i_decoded_SB_msg, COUNT_DONE_REQ)) begin
            o_lane_result       <= i_lane_error;
            o_result_pass       <= ~|i_lane_error;
            o_comparator_cw     <= CW_IDLE;
            o_encoded_SB_msg_rx <= SB_MSG_WIDTH'(COUNT_DONE_RESP);
            o_valid_rx          <= 1'b1;
            state               <= ST_SEND_CNT_RESP;
          end else if (tmo_tc) begin
            o_timeout <= 1'b1; o_comparator_cw <= CW_IDLE; o_valid_rx <= 1'b0;
            o_rx_d2c_pt_done_rx <= 1'b1; state <= ST_FINISHED;
          end

        ST_SEND_CNT_RESP:
          if (send_ok) begin
            o_valid_rx <= 1'b0;
            state      <= ST_WAIT_END;
          end

        ST_WAIT_END:
          if (i_rx_msg_valid && req_is(i_decoded_SB_msg, END_REQ)) begin
            o_encoded_SB_msg_rx <= SB_MSG_WIDTH'(END_RESP);
            o_valid_rx          <= 1'b1;
            state               <= ST_SEND_END_RESP;
          end else if (tmo_tc) begin
            o_timeout <= 1'b1; o_comparator_cw <= CW_IDLE; o_valid_rx <= 1'b0;
            o_rx_d2c_pt_done_rx <= 1'b1; state <= ST_FINISHED;
          end

        ST_SEND_END_RESP:
          if (send_ok) begin
            o_valid_rx          <= 1'b0;
            o_rx_d2c_pt_done_rx <= 1'b1;
            state               <= ST_FINISHED;
          end

        ST_FINISHED: o_rx_d2c_pt_done_rx <= 1'b1;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_d2c_point_test_responder.sv
// Directed bench for the D2C point-test responder; expected SB responses
// are queued as requests are driven and checked when the DUT answers.
module tb_rx_d2c_point_test_responder;

  localparam int SBW = 4;
  localparam int NL  = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, msg_valid, burst, fe_busy, tx_valid;
  logic [SBW-1:0] msg;
  logic [NL-1:0]  lane_err;
  logic [SBW-1:0] enc;
  logic           valid_rx, burst_o, pass, tmo, done;
  logic [1:0]     cw;
  logic [NL-1:0]  lane_res;

  int tests = 0;
  int fails = 0;
  logic [SBW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rx_d2c_point_test_responder #(
    .SB_MSG_WIDTH(SBW), .NUM_LANES(NL), .TIMEOUT_CYCLES(TMO), .TIMEOUT_W(5)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_d2c_pt_en(en),
    .i_rx_msg_valid(msg_valid), .i_decoded_SB_msg(msg), .i_sb_burst_count(burst),
    .i_falling_edge_busy(fe_busy), .i_tx_valid(tx_valid), .i_lane_error(lane_err),
    .o_encoded_SB_msg_rx(enc), .o_valid_rx(valid_rx), .o_comparator_cw(cw),
    .o_burst_count(burst_o), .o_lane_result(lane_res), .o_result_pass(pass),
    .o_timeout(tmo), .o_rx_d2c_pt_done_rx(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns later, away from the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one request; its response must appear registered after one edge.
  task automatic send_req(input logic [SBW-1:0] code, input logic b, input string tag);
    logic [SBW-1:0] want;
    msg_valid = 1'b1; msg = code; burst = b;
    exp_q.push_back(code + 4'd1);
    tick();
    msg_valid = 1'b0; msg = '0;
    chk({tag, "_valid"}, 32'(valid_rx), 32'd1);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      chk({tag, "_code"}, 32'(enc), 32'(want));
    end else chk({tag, "_queue"}, 32'd0, 32'd1);
  endtask

  task automatic busy_edge(input logic txv);
    fe_busy = 1'b1; tx_valid = txv;
    tick();
    fe_busy = 1'b0; tx_valid = 1'b0;
  endtask

  task automatic run_seq(input logic b, input logic [NL-1:0] le, input string tag);
    en = 1'b1; tick();
    send_req(4'd1, b, {tag, "_start"});
    chk({tag, "_burst"}, 32'(burst_o), 32'(b));
    busy_edge(1'b0);
    chk({tag, "_start_clr"}, 32'(valid_rx), 32'd0);
    send_req(4'd3, b, {tag, "_lclr"});
    chk({tag, "_cw_clear"}, 32'(cw), 32'd1);
    busy_edge(1'b0);
    chk({tag, "_cw_cmp"}, 32'(cw), 32'd2);
    lane_err = le;
    send_req(4'd5, b, {tag, "_cnt"});
    lane_err = '1;
    chk({tag, "_cw_idle"}, 32'(cw), 32'd0);
    chk({tag, "_result"}, 32'(lane_res), 32'(le));
    chk({tag, "_pass"}, 32'(pass), 32'(le == '0));
    busy_edge(1'b0);
    send_req(4'd7, b, {tag, "_end"});
    busy_edge(1'b0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_hold"}, 32'(done), 32'd1);
    chk({tag, "_result_hold"}, 32'(lane_res), 32'(le));
    en = 1'b0; tick();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_result"}, 32'(lane_res), 32'd0);
    chk({tag, "_idle_pass"}, 32'(pass), 32'd0);
    chk({tag, "_idle_burst"}, 32'(burst_o), 32'(b));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; msg_valid = 1'b0; msg = '0; burst = 1'b0;
    fe_busy = 1'b0; tx_valid = 1'b0; lane_err = '0;
    repeat (2) tick();
    chk("rst_outputs", {enc, valid_rx, cw, burst_o, pass, tmo, done}, 32'd0);
    chk("rst_result", 32'(lane_res), 32'd0);
    rst_n = 1'b1; tick();

    // Start handshake with burst=1, then full passing and failing sequences.
    run_seq(1'b1, 16'h0000, "pass_seq");
    run_seq(1'b0, 16'h0204, "fail_seq");

    // Initiator-owned busy edge must not release our response; no timeout in SEND.
    en = 1'b1; tick();
    send_req(4'd1, 1'b1, "share_start");
    busy_edge(1'b1);
    chk("share_hold", 32'(valid_rx), 32'd1);
    repeat (TMO + 4) tick();
    chk("send_no_tmo", {30'd0, valid_rx, tmo}, 32'd2);
    busy_edge(1'b0);
    chk("share_release", 32'(valid_rx), 32'd0);

    // Wrong code in WAIT_CLR is ignored; en drop in COMPARE returns to IDLE.
    msg_valid = 1'b1; msg = 4'd5; tick(); msg_valid = 1'b0;
    chk("wrong_code_valid", 32'(valid_rx), 32'd0);
    chk("wrong_code_cw", 32'(cw), 32'd0);
    send_req(4'd3, 1'b0, "after_wrong");
    busy_edge(1'b0);
    chk("cmp_cw", 32'(cw), 32'd2);
    en = 1'b0; tick();
    chk("en_drop_outputs", {enc, valid_rx, cw, pass, tmo, done}, 32'd0);

    // Timeout in WAIT_CLR after exactly TMO cycles.
    en = 1'b1; tick();
    send_req(4'd1, 1'b0, "tmo_start");
    busy_edge(1'b0);
    repeat (TMO - 1) tick();
    chk("tmo_early", {30'd0, tmo, done}, 32'd0);
    tick();
    chk("tmo_fire", {30'd0, tmo, done}, 32'd3);
    chk("tmo_valid_cw", {29'd0, valid_rx, cw}, 32'd0);
    en = 1'b0; tick();

    // Asynchronous reset in the middle of COMPARE.
    en = 1'b1; tick();
    send_req(4'd1, 1'b1, "rst_start");
    busy_edge(1'b0);
    send_req(4'd3, 1'b0, "rst_lclr");
    busy_edge(1'b0);
    #2 rst_n = 1'b0; #1;
    chk("async_rst", {enc, valid_rx, cw, burst_o, pass, tmo, done}, 32'd0);
    rst_n = 1'b1; en = 1'b0; tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
